// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - timed address/data bus sequencer for the external RTC chip
// Optional macro RTC_SEQ_RR_ARB_EN selects round-robin instead of fixed micro priority.
module rtc_bus_sequencer #(
  parameter int T_SETUP = 4,
  parameter int T_PULSE = 8,
  parameter int T_HOLD  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_micro,
  input  logic       we_micro,
  input  logic [7:0] addr_micro,
  input  logic [7:0] wdata_micro,
  input  logic       req_scan,
  input  logic [7:0] addr_scan,
  output logic       busy,
  output logic       done,
  output logic       done_scan,
  output logic [7:0] rdata,
  output logic       overrun,
  output logic       rtc_cs_n,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic       rtc_a_d,
  output logic [7:0] rtc_ad_out,
  output logic       rtc_ad_oe,
  input  logic [7:0] rtc_ad_in
);

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD, DONE
  } state_t;

  localparam logic [4:0] SETUP_LAST = 5'(T_SETUP - 1);
  localparam logic [4:0] PULSE_LAST = 5'(T_PULSE - 1);
  localparam logic [4:0] HOLD_LAST  = 5'(T_HOLD - 1);

  state_t     state;
  logic [4:0] cnt;
  logic       pending;
  logic       p_we;
  logic [7:0] p_addr;
  logic [7:0] p_wdata;
  logic       cur_we;
  logic       cur_scan;
  logic [7:0] cur_wdata;
  logic       grant_micro;

`ifdef RTC_SEQ_RR_ARB_EN
  logic last_scan;
  assign grant_micro = pending && (!req_scan || last_scan);
`else
  assign grant_micro = pending;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      p_we       <= 1'b0;
      p_addr     <= '0;
      p_wdata    <= '0;
      cur_we     <= 1'b0;
      cur_scan   <= 1'b0;
      cur_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_scan  <= 1'b0;
      rdata      <= '0;
      overrun    <= 1'b0;
      rtc_cs_n   <= 1'b1;
      rtc_rd_n   <= 1'b1;
      rtc_wr_n   <= 1'b1;
      rtc_a_d    <= 1'b0;
      rtc_ad_out <= '0;
      rtc_ad_oe  <= 1'b0;
`ifdef RTC_SEQ_RR_ARB_EN
      last_scan  <= 1'b1;
`endif
    end else begin
      done    <= 1'b0;
      overrun <= req_micro && pending;
      if (req_micro && !pending) begin
        pending <= 1'b1;
        p_we    <= we_micro;
        p_addr  <= addr_micro;
        p_wdata <= wdata_micro;
      end

      // Outputs are registered: each transition loads the strobes of the state being entered.
      case (state)
        IDLE: begin
          if (grant_micro || req_scan) begin
            state      <= A_SETUP;
            cnt        <= '0;
            busy       <= 1'b1;
            rtc_cs_n   <= 1'b0;
            rtc_a_d    <= 1'b0;
            rtc_ad_oe  <= 1'b1;
            if (grant_micro) begin
              pending    <= 1'b0;
              cur_we     <= p_we;
              cur_wdata  <= p_wdata;
              cur_scan   <= 1'b0;
              rtc_ad_out <= p_addr;
`ifdef RTC_SEQ_RR_ARB_EN
              last_scan  <= 1'b0;
`endif
            end else begin
              cur_we     <= 1'b0;
              cur_scan   <= 1'b1;
              rtc_ad_out <= addr_scan;
`ifdef RTC_SEQ_RR_ARB_EN
              last_scan  <= 1'b1;
`endif
            end
          end
        end
        A_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt      <= '0;
            state    <= A_PULSE;
            rtc_wr_n <= 1'b0;
          end else cnt <= cnt + 5'd1;
        end
        A_PULSE: begin
          if (cnt == PULSE_LAST) begin
            cnt      <= '0;
            state    <= A_HOLD;
            rtc_wr_n <= 1'b1;
          end else cnt <= cnt + 5'd1;
        end
        A_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            state     <= D_SETUP;
            rtc_a_d   <= 1'b1;
            rtc_ad_oe <= cur_we;
            if (cur_we) rtc_ad_out <= cur_wdata;
          end else cnt <= cnt + 5'd1;
        end
        D_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt      <= '0;
            state    <= D_PULSE;
            rtc_wr_n <= !cur_we;
            rtc_rd_n <= cur_we;
          end else cnt <= cnt + 5'd1;
        end
        D_PULSE: begin
          if (cnt == PULSE_LAST) begin
            cnt      <= '0;
            state    <= D_HOLD;
            rtc_wr_n <= 1'b1;
            rtc_rd_n <= 1'b1;
            if (!cur_we) rdata <= rtc_ad_in;
          end else cnt <= cnt + 5'd1;
        end
        D_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt       <= '0;
            state     <= DONE;
            rtc_cs_n  <= 1'b1;
            rtc_ad_oe <= 1'b0;
            rtc_a_d   <= 1'b0;
            done      <= 1'b1;
            done_scan <= cur_scan;
          end else cnt <= cnt + 5'd1;
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done_scan <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - directed self-checking bench for rtc_bus_sequencer
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_micro = 1'b0, we_micro = 1'b0, req_scan = 1'b0;
  logic [7:0] addr_micro = '0, wdata_micro = '0, addr_scan = '0, rtc_ad_in = '0;
  logic       busy, done, done_scan, overrun, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_a_d, rtc_ad_oe;
  logic [7:0] rdata, rtc_ad_out;

  logic       req_micro_f = 1'b0, req_scan_f = 1'b0;
  logic       busy_f, done_f, done_scan_f, overrun_f, cs_n_f, rd_n_f, wr_n_f, a_d_f, oe_f;
  logic [7:0] rdata_f, ad_out_f;

  int vectors = 0, miscompares = 0;
  int n_cs, n_wr_a, n_wr_d, n_wr, n_rd, n_rd_all, n_oe_d, n_excl, n_done, done_at, ds, busy_end, busy1;

  always #5 clk = ~clk;

  rtc_bus_sequencer dut (
    .clk(clk), .reset(reset), .req_micro(req_micro), .we_micro(we_micro),
    .addr_micro(addr_micro), .wdata_micro(wdata_micro), .req_scan(req_scan),
    .addr_scan(addr_scan), .busy(busy), .done(done), .done_scan(done_scan),
    .rdata(rdata), .overrun(overrun), .rtc_cs_n(rtc_cs_n), .rtc_rd_n(rtc_rd_n),
    .rtc_wr_n(rtc_wr_n), .rtc_a_d(rtc_a_d), .rtc_ad_out(rtc_ad_out),
    .rtc_ad_oe(rtc_ad_oe), .rtc_ad_in(rtc_ad_in)
  );

  rtc_bus_sequencer #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut_fast (
    .clk(clk), .reset(reset), .req_micro(req_micro_f), .we_micro(we_micro),
    .addr_micro(addr_micro), .wdata_micro(wdata_micro), .req_scan(req_scan_f),
    .addr_scan(addr_scan), .busy(busy_f), .done(done_f), .done_scan(done_scan_f),
    .rdata(rdata_f), .overrun(overrun_f), .rtc_cs_n(cs_n_f), .rtc_rd_n(rd_n_f),
    .rtc_wr_n(wr_n_f), .rtc_a_d(a_d_f), .rtc_ad_out(ad_out_f),
    .rtc_ad_oe(oe_f), .rtc_ad_in(rtc_ad_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples one main transaction from cycle 1 (first A_SETUP) to cycle 34.
  task automatic watch(input logic [7:0] a, input logic [7:0] d);
    n_cs = 0; n_wr_a = 0; n_wr_d = 0; n_wr = 0; n_rd = 0; n_rd_all = 0;
    n_oe_d = 0; n_excl = 0; n_done = 0; done_at = -1; ds = -1; busy1 = 0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = int'(busy);
      if (!rtc_cs_n) n_cs++;
      if (!rtc_wr_n) n_wr++;
      if (!rtc_rd_n) n_rd_all++;
      if (!rtc_wr_n && c >= 5 && c <= 12 && !rtc_a_d && rtc_ad_oe && rtc_ad_out == a) n_wr_a++;
      if (!rtc_wr_n && c >= 21 && c <= 28 && rtc_a_d && rtc_ad_oe && rtc_ad_out == d) n_wr_d++;
      if (!rtc_rd_n && c >= 21 && c <= 28 && rtc_a_d) n_rd++;
      if (rtc_a_d && rtc_ad_oe) n_oe_d++;
      if ((!rtc_wr_n && !rtc_rd_n) || (!rtc_rd_n && rtc_ad_oe)) n_excl++;
      if (done) begin n_done++; done_at = c; ds = int'(done_scan); req_scan = 1'b0; end
      busy_end = int'(busy);
      rtc_ad_in = (c == 28) ? 8'h59 : 8'(8'hA0 + c);
    end
  endtask

  task automatic watch_fast();
    n_excl = 0; n_rd = 0; done_at = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (!rd_n_f) n_rd++;
      if ((!wr_n_f && !rd_n_f) || (!rd_n_f && oe_f)) n_excl++;
      if (done_f && done_at < 0) begin done_at = c; req_scan_f = 1'b0; end
    end
  endtask

  task automatic wait_done(input string tag, output int dsv);
    dsv = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin dsv = int'(done_scan); break; end
    end
    if (dsv < 0) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic pulse_micro(input logic we, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    req_micro = 1'b1; we_micro = we; addr_micro = a; wdata_micro = d;
    @(negedge clk);
    req_micro = 1'b0;
  endtask

  initial begin
    int d1, d2, d3, d4;
    repeat (3) @(negedge clk);
    check("rst_strobes", {rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_a_d, rtc_ad_oe}, 5'b11100);
    check("rst_status", {busy, done, done_scan, overrun}, 4'b0000);
    check("rst_data", {rdata, rtc_ad_out}, 16'h0000);
    reset = 1'b1;

    // Micro write 0x21/0x45
    pulse_micro(1'b1, 8'h21, 8'h45);
    watch(8'h21, 8'h45);
    check("wr_busy_c1", busy1, 1);
    check("wr_cs_low", n_cs, 32);
    check("wr_addr_pulse", n_wr_a, 8);
    check("wr_data_pulse", n_wr_d, 8);
    check("wr_total_low", n_wr, 16);
    check("wr_no_rd", n_rd_all, 0);
    check("wr_oe_data", n_oe_d, 16);
    check("wr_done_cycle", done_at, 33);
    check("wr_done_count", n_done, 1);
    check("wr_done_scan", ds, 0);
    check("wr_excl", n_excl, 0);
    check("wr_idle_after", busy_end, 0);

    // Scan read 0x22, bus returns 0x59 on the last D_PULSE cycle
    @(negedge clk);
    req_scan = 1'b1; addr_scan = 8'h22;
    watch(8'h22, 8'h00);
    check("rd_addr_pulse", n_wr_a, 8);
    check("rd_rd_low", n_rd, 8);
    check("rd_rd_total", n_rd_all, 8);
    check("rd_no_wr_data", n_wr, 8);
    check("rd_oe_data", n_oe_d, 0);
    check("rd_rdata", rdata, 8'h59);
    check("rd_done_cycle", done_at, 33);
    check("rd_done_scan", ds, 1);
    check("rd_excl", n_excl, 0);

    // Overrun: X in flight, B pends, C dropped
    pulse_micro(1'b1, 8'h10, 8'h11);
    repeat (3) @(negedge clk);
    @(negedge clk);
    req_micro = 1'b1; addr_micro = 8'h30; wdata_micro = 8'h31;
    @(negedge clk);
    addr_micro = 8'h40; wdata_micro = 8'h41;
    @(negedge clk);
    req_micro = 1'b0;
    check("ovr_pulse", overrun, 1'b1);
    @(negedge clk);
    check("ovr_once", overrun, 1'b0);
    wait_done("ovr_x", d1);
    check("ovr_x_micro", d1, 0);
    @(negedge clk);
    watch(8'h30, 8'h31);
    check("ovr_b_addr", n_wr_a, 8);
    check("ovr_b_data", n_wr_d, 8);
    check("ovr_b_done", done_at, 33);
    check("ovr_rdata_held", rdata, 8'h59);

    // Contention: simultaneous arrival grants scan, then ties at IDLE
    @(negedge clk);
    req_micro = 1'b1; we_micro = 1'b1; addr_micro = 8'h50; wdata_micro = 8'h51;
    req_scan = 1'b1; addr_scan = 8'h60;
    @(negedge clk);
    req_micro = 1'b0;
    wait_done("arb1", d1);
    repeat (5) @(negedge clk);
    pulse_micro(1'b1, 8'h70, 8'h71);
    wait_done("arb2", d2);
    wait_done("arb3", d3);
    wait_done("arb4", d4);
    req_scan = 1'b0;
`ifdef RTC_SEQ_RR_ARB_EN
    check("arb_order", {d1[0], d2[0], d3[0], d4[0]}, 4'b1010);
`else
    check("arb_order", {d1[0], d2[0], d3[0], d4[0]}, 4'b1001);
`endif
    repeat (2) @(negedge clk);
    check("arb_idle", busy, 1'b0);

    // Reset during D_PULSE of a write
    pulse_micro(1'b1, 8'h21, 8'h45);
    repeat (24) @(negedge clk);
    check("mid_in_pulse", rtc_wr_n, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_strobes", {rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_ad_oe, busy}, 5'b11100);
    check("mid_rdata", rdata, 8'h00);
    n_done = 0;
    repeat (2) @(negedge clk) if (done) n_done++;
    reset = 1'b1;
    repeat (3) @(negedge clk) if (done) n_done++;
    check("mid_no_done", n_done, 0);
    pulse_micro(1'b1, 8'h33, 8'h44);
    watch(8'h33, 8'h44);
    check("post_rst_done", done_at, 33);
    check("post_rst_data", n_wr_d, 8);

    // Minimum timing instance
    @(negedge clk);
    req_micro_f = 1'b1; we_micro = 1'b1; addr_micro = 8'h12; wdata_micro = 8'h34;
    @(negedge clk);
    req_micro_f = 1'b0;
    watch_fast();
    check("fast_wr_done", done_at, 7);
    check("fast_wr_excl", n_excl, 0);
    @(negedge clk);
    req_scan_f = 1'b1; addr_scan = 8'h13;
    watch_fast();
    check("fast_rd_done", done_at, 7);
    check("fast_rd_low", n_rd, 1);
    check("fast_rd_excl", n_excl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
